// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : shared constants for the stopwatch (dividers, digit selects, segments)
// Rev 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam int unsigned TICK_DIV_DEF = 1_000_000;
  localparam int unsigned SCAN_DIV_DEF = 100_000;
  localparam int unsigned INC_DIV_DEF  = 10_000_000;

  // Active-low digit enables, index = digit slot (0 = rightmost)
  localparam logic [3:0] AN_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..9
  localparam logic [6:0] SEG_PAT [10] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_0000
  };

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

endpackage

`default_nettype wire

// File: rtl/timer_seg7_decode.sv
// ============================================================================
// seg7_decode : BCD digit to active-low 7-segment pattern, non-BCD codes blank
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_PAT[bcd_i];
  end

endmodule

`default_nettype wire

// File: rtl/timer.sv
// ============================================================================
// timer : 4-digit BCD stopwatch (00.00-99.99) with multiplexed 7-segment output
// Rev 1.0
// ============================================================================
`default_nettype none

module timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  parameter int unsigned INC_DIV  = INC_DIV_DEF
) (
  input  logic       CLK_100M,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       INC,
  output logic [7:0] SEG,
  output logic [3:0] AN,
  output logic       RUN
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (INC_DIV  > 1) ? $clog2(INC_DIV)  : 1;

  logic            start_prev_q, stop_prev_q, inc_prev_q;
  logic            run_q, run_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]   inc_cnt_q, inc_cnt_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0][3:0] digits_q, digits_d;
  logic [3:0]      an_q;
  logic [7:0]      seg_q;

  logic       start_rise, stop_rise, inc_rise;
  logic       tick_fire, inc_fire, carry;
  logic [6:0] seg_raw;

  assign start_rise = START & ~start_prev_q;
  assign stop_rise  = STOP  & ~stop_prev_q;
  assign inc_rise   = INC   & ~inc_prev_q;

  // Run flag and tick prescaler; the prescaler restarts only on a real start
  always_comb begin
    run_d = run_q;
    if (stop_rise)       run_d = 1'b0;
    else if (start_rise) run_d = 1'b1;

    tick_cnt_d = tick_cnt_q;
    tick_fire  = 1'b0;
    if (start_rise && !stop_rise && !run_q) begin
      tick_cnt_d = '0;
    end else if (run_q) begin
      if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
        tick_cnt_d = '0;
        tick_fire  = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end
  end

  // Manual increment: immediate step on INC rise, then auto-repeat while held
  always_comb begin
    inc_cnt_d = inc_cnt_q;
    inc_fire  = 1'b0;
    if (!run_q && !start_rise && INC) begin
      if (inc_rise || inc_cnt_q == IW'(INC_DIV - 1)) begin
        inc_fire  = 1'b1;
        inc_cnt_d = '0;
      end else begin
        inc_cnt_d = inc_cnt_q + IW'(1);
      end
    end
  end

  always_comb begin
    digits_d = digits_q;
    carry    = tick_fire | inc_fire;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digits_q[i] == 4'd9) begin
          digits_d[i] = 4'd0;
        end else begin
          digits_d[i] = digits_q[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    sel_d      = sel_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      sel_d      = sel_q + 2'd1;
    end
  end

  seg7_decode u_seg7_decode (
    .bcd_i (digits_q[sel_q]),
    .seg_o (seg_raw)
  );

  always_ff @(posedge CLK_100M) begin
    if (!RST) begin
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      inc_prev_q   <= 1'b0;
      run_q        <= 1'b0;
      tick_cnt_q   <= '0;
      inc_cnt_q    <= '0;
      scan_cnt_q   <= '0;
      sel_q        <= 2'd0;
      digits_q     <= '0;
      an_q         <= AN_SEL[0];
      seg_q        <= {1'b1, SEG_PAT[0]};
    end else begin
      start_prev_q <= START;
      stop_prev_q  <= STOP;
      inc_prev_q   <= INC;
      run_q        <= run_d;
      tick_cnt_q   <= tick_cnt_d;
      inc_cnt_q    <= inc_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      sel_q        <= sel_d;
      digits_q     <= digits_d;
      // AN and SEG both derive from sel_q so they switch on the same edge
      an_q         <= AN_SEL[sel_q];
      seg_q        <= {(sel_q != 2'd2), seg_raw};
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign RUN = run_q;

endmodule

`default_nettype wire

// File: tb/tb_timer.sv
// ============================================================================
// tb_timer : directed self-checking bench for the timer stopwatch
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_timer;

  localparam logic [6:0] SEG_REF [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [3:0] AN_EXP  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [7:0] SEG_EXP [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};

  logic       clk;
  logic       rst;
  logic       start, stop, inc;
  logic [7:0] seg;
  logic [3:0] an;
  logic       run;

  int n_vec  = 0;
  int n_miss = 0;

  timer #(
    .TICK_DIV (4),
    .SCAN_DIV (2),
    .INC_DIV  (8)
  ) dut (
    .CLK_100M (clk),
    .RST      (rst),
    .START    (start),
    .STOP     (stop),
    .INC      (inc),
    .SEG      (seg),
    .AN       (an),
    .RUN      (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reassemble the displayed count from one full 8-clock scan
  task automatic read_display(output logic [15:0] val);
    logic [3:0] d [4];
    logic [3:0] v;
    int         idx;
    bit         bad;
    for (int i = 0; i < 4; i++) d[i] = 4'hF;
    bad = 1'b0;
    repeat (8) begin
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: begin idx = -1; bad = 1'b1; end
      endcase
      v = 4'hF;
      for (int k = 0; k < 10; k++) if (seg[6:0] == SEG_REF[k]) v = 4'(k);
      if (idx >= 0) begin
        d[idx] = v;
        if (seg[7] != (idx != 2)) bad = 1'b1;
      end
      step(1);
    end
    chk("disp_an_dp", {31'b0, bad}, 32'd0);
    val = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic inc_pulses(input int n);
    repeat (n) begin
      inc = 1'b1; step(1);
      inc = 1'b0; step(1);
    end
  endtask

  logic [15:0] cnt;
  logic [3:0]  an_prev;
  bit          found;

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; inc = 1'b0;

    // Reset state
    step(5);
    chk("rst_run", run, 0);
    chk("rst_an",  an,  4'b1110);
    chk("rst_seg", seg, 8'hC0);
    rst = 1'b1;
    read_display(cnt);
    chk("rst_count", cnt, 16'h0000);

    // Run 40 clocks = 10 ticks, then stop and stay frozen
    start = 1'b1; step(2);
    chk("run_after_start", run, 1);
    start = 1'b0; step(40);
    stop = 1'b1; step(1);
    chk("run_after_stop", run, 0);
    stop = 1'b0;
    read_display(cnt);
    chk("count_0010", cnt, 16'h0010);
    step(100);
    read_display(cnt);
    chk("count_frozen", cnt, 16'h0010);

    // INC held 100 clocks while stopped: +13
    inc = 1'b1; step(100);
    inc = 1'b0; step(1);
    read_display(cnt);
    chk("count_inc_hold", cnt, 16'h0023);

    // INC during run is ignored: only 5 ticks land
    start = 1'b1; step(1);
    start = 1'b0; inc = 1'b1; step(19);
    chk("run_with_inc", run, 1);
    inc = 1'b0; stop = 1'b1; step(1);
    stop = 1'b0;
    chk("run_off_inc", run, 0);
    read_display(cnt);
    chk("count_inc_ignored", cnt, 16'h0028);

    // Simultaneous START/STOP edges: STOP wins
    start = 1'b1; stop = 1'b1; step(1);
    chk("both_edge_run", run, 0);
    step(1);
    chk("both_held_run", run, 0);
    start = 1'b0; stop = 1'b0; step(1);
    read_display(cnt);
    chk("count_after_both", cnt, 16'h0028);

    // Reset mid-run
    start = 1'b1; step(1);
    start = 1'b0; step(9);
    chk("run_before_rst", run, 1);
    rst = 1'b0; step(1);
    chk("midrst_run", run, 0);
    chk("midrst_an",  an,  4'b1110);
    chk("midrst_seg", seg, 8'hC0);
    rst = 1'b1; step(3);
    chk("post_rst_run", run, 0);
    read_display(cnt);
    chk("midrst_count", cnt, 16'h0000);

    // Preload 99.99, then 4 ticks wraps to 00.03
    inc_pulses(9999);
    read_display(cnt);
    chk("count_9999", cnt, 16'h9999);
    start = 1'b1; step(2);
    start = 1'b0; step(15);
    chk("run_through_wrap", run, 1);
    stop = 1'b1; step(1);
    stop = 1'b0;
    read_display(cnt);
    chk("count_wrap_0003", cnt, 16'h0003);

    // Scan sequence with 12.34
    inc_pulses(1231);
    read_display(cnt);
    chk("count_1234", cnt, 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      an_prev = an;
      step(1);
      if (an == 4'b1110 && an_prev != 4'b1110) found = 1'b1;
    end
    chk("scan_sync", {31'b0, found}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("scan_an_%0d", k),  an,  AN_EXP[(k % 8) / 2]);
      chk($sformatf("scan_seg_%0d", k), seg, SEG_EXP[(k % 8) / 2]);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter TICK_DIV, default 1_000_000, meaning clocks per 10 ms count tick (100 MHz clock).
REQ-002 Parameter SCAN_DIV, default 100_000, meaning clocks per display digit slot (1 kHz per digit).
REQ-003 Parameter INC_DIV, default 10_000_000, meaning clocks between auto-repeat increments while INC is held.
REQ-004 CLK_100M  input  1  sole clock, 100 MHz, all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 START  input  1  start request, level, synchronous to CLK_100M.
REQ-007 STOP  input  1  stop request, level, synchronous to CLK_100M.
REQ-008 INC  input  1  manual increment request while stopped.
REQ-009 SEG  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}.
REQ-010 AN  output  4  active-low one-hot digit enable; AN[0] rightmost digit.
REQ-011 RUN  output  1  high while stopwatch is counting.

Function
REQ-012 Count shall be 4 BCD digits D3 D2 . D1 D0 (seconds tens, seconds units, tenths, hundredths), range 00.00-99.99.
REQ-013 START and STOP shall be rising-edge detected internally (1-cycle registered previous value); a held level acts once.
REQ-014 START rising edge shall set RUN=1 on the next clock and clear the tick prescaler; STOP rising edge shall set RUN=0 on the next clock.
REQ-015 Simultaneous START and STOP rising edges: STOP wins, RUN=0.
REQ-016 While RUN=1, the count shall advance by one hundredth every TICK_DIV clocks; prescaler holds its value while RUN=0.
REQ-017 BCD carry: digit 9 rolls to 0 and carries; 99.99 wraps to 00.00 and counting continues with RUN unchanged.
REQ-018 While RUN=0 and INC=1: first +1 hundredth on the clock after INC rises, then +1 every INC_DIV clocks while held; same carry/wrap rules.
REQ-019 INC shall be ignored while RUN=1; a START edge while INC held starts counting and suspends INC.
REQ-020 START while already running and STOP while stopped shall have no effect; count is retained across stop/start.
REQ-021 Display scan counter shall cycle digits 0,1,2,3 every SCAN_DIV clocks, AN = 1110,1101,1011,0111 respectively; exactly one AN bit low at all times.
REQ-022 SEG shall show the selected digit's BCD value with standard 7-segment patterns (0 = 1100_0000 ... 9 = 1001_0000); dp (SEG[7]) low only while digit 2 is selected.
REQ-023 SEG and AN shall be registered and change in the same clock; display runs regardless of RUN.

Reset
REQ-024 On a clock edge with RST=0: count=00.00, RUN=0, all prescalers/scan counter=0, edge-detect registers=0, AN=1110, SEG=1100_0000.
REQ-025 Reset shall override START/STOP/INC in the same cycle; reset mid-run stops counting and clears the count; operation resumes only after RST=1 and a new START edge.

Structure
REQ-026 Shared package timer_pkg shall hold default TICK_DIV/SCAN_DIV/INC_DIV values, digit-select AN patterns and the 10 segment patterns.
REQ-027 One sub-module seg7_decode (4-bit BCD in, 7-bit active-low segments out, combinational; values 10-15 blank = 111_1111).
REQ-028 Top module contains edge detectors, RUN flag, tick/INC/scan prescalers, BCD counter chain and display mux.

Verification (bench uses TICK_DIV=4, SCAN_DIV=2, INC_DIV=8)
REQ-029 RST=0 for 5 clocks then 1 -> RUN=0, AN=1110, SEG=1100_0000, count 00.00.
REQ-030 START pulse 2 clocks, wait 40 clocks, STOP pulse -> RUN 1 then 0, count 00.10 (±1 LSB by edge alignment), then frozen for 100 clocks.
REQ-031 INC held 100 clocks while stopped -> count increases by 1+floor(99/8)=13 hundredths; INC during RUN=1 -> no extra increment.
REQ-032 Preload 99.99 via INC, START, 4 ticks -> count reads 00.03, RUN stays 1.
REQ-033 START and STOP rising in same clock -> RUN=0; RST=0 during run -> next clock RUN=0, count 00.00.
REQ-034 Scan check with count 12.34 -> AN/SEG sequence: 1110/"4", 1101/"3", 1011/"2"+dp, 0111/"1", repeating every 8 clocks.
